csr_file: RTL
=============

# csr_file

Machine-mode control and status register file for the core. It is the storage end of the CSR write/read path: it accepts the write-back stage's CSR write request and serves the decode-stage CSR read. The forwarding block sits in front of its read port. It also holds the free-running cycle and retired-instruction counters and performs the architectural state updates for trap entry and `mret`.

## Interface
- `MTVEC_RESET`, default 32'h0000_0000: reset value of `mtvec`.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `w_csr_req_i`  in  1  CSR write enable; `write_reg_req_enable` means write.
- `w_csr_addr_i`  in  12 (`csr_addr_bus`)  write address.
- `w_csr_data_i`  in  32 (`csr_data_bus`)  write data.
- `r_csr_addr_i`  in  12  read address.
- `r_csr_data_o`  out  32  read data; combinational from current state.
- `retire_i`  in  1  one instruction retired this cycle.
- `trap_i`  in  1  trap entry this cycle.
- `trap_pc_i`  in  32  PC saved into `mepc` on trap.
- `trap_cause_i`  in  32  value saved into `mcause` on trap.
- `mret_i`  in  1  `mret` retires this cycle.
- `timer_irq_i`  in  1  level timer interrupt; drives `mip.MTIP`.
- `mtvec_o`  out  32  current `mtvec`.
- `mepc_o`  out  32  current `mepc`.
- `irq_pending_o`  out  1  `mstatus.MIE & mie.MTIE & timer_irq_i`.

## Operation
- Implemented registers and write behaviour:
  - `mstatus` 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - `mie` 0x304: only MTIE[7] is writable.
  - `mtvec` 0x305: fully writable.
  - `mscratch` 0x340: fully writable.
  - `mepc` 0x341: bits[1:0] are forced to 0 on every write.
  - `mcause` 0x342: fully writable.
  - `mip` 0x344: read-only; bit7 = `timer_irq_i`, other bits 0.
- Counters:
  - `mcycle` 0xB00 / `mcycleh` 0xB80 form one 64-bit counter. It increments every cycle outside reset and wraps from all-ones to 0.
  - `minstret` 0xB02 / `minstreth` 0xB82 form one 64-bit counter. It increments when `retire_i` is set and also wraps.
  - Read-only shadows: `cycle`/`cycleh` at 0xC00/0xC80 and `instret`/`instreth` at 0xC02/0xC82.
- Unimplemented or read-only addresses: reads return 0 (read-only shadows return their counter value); writes are ignored with no side effect.
- Counter writes: the written 32-bit half takes the written value that cycle and does not increment. The other half is unchanged, and no carry is applied into it that cycle.
- Trap entry (`trap_i`):
  - `mepc` <= {`trap_pc_i`[31:2], 2'b00}; `mcause` <= `trap_cause_i`.
  - MPIE <= MIE; MIE <= 0.
- `mret_i`: MIE <= MPIE; MPIE <= 1.
- Simultaneous events, in priority order:
  - `trap_i` over `mret_i`.
  - Trap/mret updates of `mstatus`/`mepc`/`mcause` over a software write to the same register in the same cycle; the software write to that register is dropped.
  - Writes to other registers in the same cycle still take effect.
- `r_csr_data_o` is not forwarded internally. A read and a write to the same address in the same cycle returns the old value; the upstream forwarding block supplies the new one.

## Timing
- Read: zero latency, combinational.
- Write, trap and mret updates are visible on `r_csr_data_o` and the status outputs one cycle after the request edge.
- Reset values (while `rst_n`=0 at a clock edge):
  - `mstatus` MIE=0, MPIE=0; `mie`=0.
  - `mtvec`=`MTVEC_RESET`; `mscratch`=`mepc`=`mcause`=0.
  - Both counters = 0.
  - Resulting outputs: `mtvec_o`=`MTVEC_RESET`, `mepc_o`=0, `irq_pending_o`=0.
- Reset asserted mid-operation overrides all pending writes, traps and increments in that cycle. `mcycle` counts 0 on the first cycle after release and 1 on the next.

## Configuration
- `CSR_INSTRET_EN` defined: `minstret`/`minstreth` and the `instret`/`instreth` shadows are implemented as above.
- Not defined: those four addresses read 0 and ignore writes, `retire_i` is unused, and no 64-bit instret counter is synthesized.

## Test plan
- Reset, then read 0x305 and 0x300 -> `MTVEC_RESET` and 32'h0000_1800; `irq_pending_o`=0.
- Write 0x341 = 32'h8000_0007, read next cycle -> 32'h8000_0004. Write 0x344 = 32'hFFFF_FFFF -> reads 0 with `timer_irq_i`=0.
- Set MIE and MTIE, assert `timer_irq_i` -> `irq_pending_o`=1. Then apply `trap_i` with pc 32'h100 and cause 32'h8000_0007 -> `mepc`=32'h100, `mcause`=32'h8000_0007, MIE=0, MPIE=1. Then `mret_i` -> MIE=1, MPIE=1.
- `trap_i` and a software write of 32'hDEAD_BEEC to `mepc` in the same cycle -> `mepc` = trap pc. A simultaneous `mscratch` write in that cycle still lands.
- Write `mcycle` = 32'hFFFF_FFFF with `mcycleh`=0 -> next cycle low=32'hFFFF_FFFF, high=0; one cycle later low=0, high=1.
- With `CSR_INSTRET_EN`, pulse `retire_i` 3 times -> 0xB02 reads 3. Without the macro, the same stimulus -> 0xB02 reads 0.

Source files
------------

// File: rtl/csr_file_if.sv
// CSR access bus between the pipeline and csr_file: the write-back stage's
// write request and the decode-stage read port.
interface csr_file_if;
  logic        w_csr_req_i;
  logic [11:0] w_csr_addr_i;
  logic [31:0] w_csr_data_i;
  logic [11:0] r_csr_addr_i;
  logic [31:0] r_csr_data_o;

  modport master (
    output w_csr_req_i, w_csr_addr_i, w_csr_data_i, r_csr_addr_i,
    input  r_csr_data_o
  );

  modport slave (
    input  w_csr_req_i, w_csr_addr_i, w_csr_data_i, r_csr_addr_i,
    output r_csr_data_o
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: status/trap registers, 64-bit mcycle and, with
// CSR_INSTRET_EN defined, the 64-bit minstret counter and its shadows.
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  csr_file_if.slave   csr,
  input  logic        retire_i,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        mret_i,
  input  logic        timer_irq_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending_o
);

  logic        we;
  logic [11:0] wa;
  logic [31:0] wd;

  assign we = csr.w_csr_req_i;
  assign wa = csr.w_csr_addr_i;
  assign wd = csr.w_csr_data_i;

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        mtie_q, mtie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;

  logic [1:0] unused_pc_lsb;
  assign unused_pc_lsb = trap_pc_i[1:0];

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;

    // A written half freezes the whole counter for that cycle (no carry).
    if (we && wa == 12'hB00)      mcycle_d = {mcycle_q[63:32], wd};
    else if (we && wa == 12'hB80) mcycle_d = {wd, mcycle_q[31:0]};
    else                          mcycle_d = mcycle_q + 64'd1;

    if (we) begin
      case (wa)
        12'h300: begin
          mie_d  = wd[3];
          mpie_d = wd[7];
        end
        12'h304: mtie_d     = wd[7];
        12'h305: mtvec_d    = wd;
        12'h340: mscratch_d = wd;
        12'h341: mepc_d     = {wd[31:2], 2'b00};
        12'h342: mcause_d   = wd;
        default: ;
      endcase
    end

    // Trap/mret come last so they override software writes to the same register.
    if (trap_i) begin
      mepc_d   = {trap_pc_i[31:2], 2'b00};
      mcause_d = trap_cause_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mcycle_q   <= 64'd0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
    end
  end

`ifdef CSR_INSTRET_EN
  logic [63:0] minstret_q, minstret_d;

  always_comb begin
    minstret_d = minstret_q;
    if (we && wa == 12'hB02)      minstret_d = {minstret_q[63:32], wd};
    else if (we && wa == 12'hB82) minstret_d = {wd, minstret_q[31:0]};
    else if (retire_i)            minstret_d = minstret_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) minstret_q <= 64'd0;
    else        minstret_q <= minstret_d;
  end
`else
  logic unused_retire;
  assign unused_retire = retire_i;
`endif

  always_comb begin
    csr.r_csr_data_o = 32'd0;
    case (csr.r_csr_addr_i)
      12'h300: csr.r_csr_data_o = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      12'h304: csr.r_csr_data_o = {24'd0, mtie_q, 7'd0};
      12'h305: csr.r_csr_data_o = mtvec_q;
      12'h340: csr.r_csr_data_o = mscratch_q;
      12'h341: csr.r_csr_data_o = mepc_q;
      12'h342: csr.r_csr_data_o = mcause_q;
      12'h344: csr.r_csr_data_o = {24'd0, timer_irq_i, 7'd0};
      12'hB00, 12'hC00: csr.r_csr_data_o = mcycle_q[31:0];
      12'hB80, 12'hC80: csr.r_csr_data_o = mcycle_q[63:32];
`ifdef CSR_INSTRET_EN
      12'hB02, 12'hC02: csr.r_csr_data_o = minstret_q[31:0];
      12'hB82, 12'hC82: csr.r_csr_data_o = minstret_q[63:32];
`endif
      default: csr.r_csr_data_o = 32'd0;
    endcase
  end

  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign irq_pending_o = mie_q & mtie_q & timer_irq_i;

endmodule
